// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared constants for the Wishbone UART slice: word addresses of the
//   register map, STATUS bit positions and the TX/RX state encodings.
// ----------------------------------------------------------------------------
package uart_pkg;

   // Word addresses on wb_adr
   localparam logic [1:0] ADR_DATA   = 2'd0;
   localparam logic [1:0] ADR_STATUS = 2'd1;
   localparam logic [1:0] ADR_BAUD   = 2'd2;

   // STATUS register bit positions
   localparam int unsigned ST_RX_AVAIL = 0;
   localparam int unsigned ST_TX_FULL  = 1;
   localparam int unsigned ST_TX_IDLE  = 2;
   localparam int unsigned ST_FERR     = 3;
   localparam int unsigned ST_OVR      = 4;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // RX_BREAK: stop bit was 0, hold off until the line returns high
   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rx_state_t;

endpackage

// File: rtl/wb_uart_if.sv
// ----------------------------------------------------------------------------
// wb_uart_if
//   Wishbone classic bus bundle for the UART slave (16-bit data, 2-bit word
//   address).
//   master : drives wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i; samples
//            wb_dat_o, wb_ack
//   slave  : the reverse
// ----------------------------------------------------------------------------
interface wb_uart_if;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [1:0]  wb_adr;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
      input  wb_dat_o, wb_ack
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
      output wb_dat_o, wb_ack
   );
endinterface

// File: rtl/uart_fifo.sv
// ----------------------------------------------------------------------------
// uart_fifo
//   Small synchronous first-word-fall-through FIFO.
//   clk, reset_n : clock, async active-low reset (clears pointers only)
//   push, din    : write request / data (ignored when full unless popping)
//   pop          : read request (ignored when empty)
//   dout         : head entry, valid while !empty
//   full, empty  : status
// ----------------------------------------------------------------------------
module uart_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   // Extra MSB on each pointer distinguishes full from empty on wrap
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push at full is honoured
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/wb_uart.sv
// ----------------------------------------------------------------------------
// wb_uart
//   Wishbone classic slave UART, 8N1, programmable divisor, TX/RX FIFOs.
//   clk     : system clock
//   reset_n : async active-low reset
//   wb      : Wishbone slave bundle (cyc/stb/we/adr/dat_i in, dat_o/ack out)
//   uart_rx : serial input (asynchronous, synchronised internally)
//   uart_tx : serial output, idles high
//   Registers: 0 DATA, 1 STATUS (W1C ferr/ovr), 2 BAUD, 3 reserved.
// ----------------------------------------------------------------------------
module wb_uart
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd868
) (
   input  logic      clk,
   input  logic      reset_n,
   wb_uart_if.slave  wb,
   input  logic      uart_rx,
   output logic      uart_tx
);

   // ---------------------------------------------------------------- bus
   logic        ack_q;
   logic [15:0] dat_q;
   logic [15:0] div_q;
   logic        ferr_q;
   logic        ovr_q;
   logic        req, wr, rd;
   logic [15:0] status;
   logic [15:0] rd_data;

   logic       tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0] tx_dout;
   logic       rx_push, rx_pop, rx_full, rx_empty, rx_ferr;
   logic [7:0] rx_dout;

   tx_state_t  tx_state;
   rx_state_t  rx_state;

   assign req = wb.wb_cyc & wb.wb_stb & ~ack_q;
   assign wr  = req & wb.wb_we;
   assign rd  = req & ~wb.wb_we;

   assign tx_push = wr && (wb.wb_adr == ADR_DATA);
   assign rx_pop  = rd && (wb.wb_adr == ADR_DATA) && !rx_empty;

   always_comb begin
      status              = '0;
      status[ST_RX_AVAIL] = ~rx_empty;
      status[ST_TX_FULL]  = tx_full;
      status[ST_TX_IDLE]  = tx_empty && (tx_state == TX_IDLE);
      status[ST_FERR]     = ferr_q;
      status[ST_OVR]      = ovr_q;
   end

   always_comb begin
      rd_data = '0;
      case (wb.wb_adr)
         ADR_DATA:   rd_data = rx_empty ? 16'h0000 : {8'h00, rx_dout};
         ADR_STATUS: rd_data = status;
         ADR_BAUD:   rd_data = div_q;
         default:    rd_data = '0;
      endcase
   end

   // dat_q is only loaded on the acking edge, so it reads 0 outside ack
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_q <= 1'b0;
         dat_q <= '0;
         div_q <= DIV_RESET;
      end else begin
         ack_q <= req;
         dat_q <= rd ? rd_data : 16'h0000;
         if (wr && (wb.wb_adr == ADR_BAUD))
            div_q <= (wb.wb_dat_i < 16'd2) ? 16'd2 : wb.wb_dat_i;
      end
   end

   // Clear first, set last: a set in the same cycle as W1C wins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         if (wr && (wb.wb_adr == ADR_STATUS)) begin
            if (wb.wb_dat_i[ST_FERR]) ferr_q <= 1'b0;
            if (wb.wb_dat_i[ST_OVR])  ovr_q  <= 1'b0;
         end
         if (rx_ferr) ferr_q <= 1'b1;
         if (rx_push && rx_full && !rx_pop) ovr_q <= 1'b1;
      end
   end

   assign wb.wb_ack   = ack_q;
   assign wb.wb_dat_o = dat_q;

   // ---------------------------------------------------------------- FIFOs
   uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (tx_push),
      .din     (wb.wb_dat_i[7:0]),
      .pop     (tx_pop),
      .dout    (tx_dout),
      .full    (tx_full),
      .empty   (tx_empty)
   );

   logic [7:0] rx_shift;

   uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (rx_push),
      .din     (rx_shift),
      .pop     (rx_pop),
      .dout    (rx_dout),
      .full    (rx_full),
      .empty   (rx_empty)
   );

   // ---------------------------------------------------------------- TX
   logic [15:0] tx_cnt;
   logic [15:0] tx_div;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shift;
   logic        tx_q;
   logic        tx_end;

   // tx_div is latched at frame start so BAUD writes never stretch a frame
   assign tx_end = (tx_cnt == tx_div - 16'd1);
   assign tx_pop = !tx_empty &&
                   ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_end));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_div   <= DIV_RESET;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_q     <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               tx_q <= 1'b1;
               if (tx_pop) begin
                  tx_shift <= tx_dout;
                  tx_div   <= div_q;
                  tx_cnt   <= '0;
                  tx_q     <= 1'b0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_end) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx_q     <= tx_shift[0];
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            TX_DATA: begin
               if (tx_end) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_q     <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_q     <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            TX_STOP: begin
               if (tx_end) begin
                  tx_cnt <= '0;
                  if (tx_pop) begin
                     tx_shift <= tx_dout;
                     tx_div   <= div_q;
                     tx_q     <= 1'b0;
                     tx_state <= TX_START;
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   assign uart_tx = tx_q;

   // ---------------------------------------------------------------- RX
   logic        rx_s1, rx_s2;
   logic [15:0] rx_cnt;
   logic [15:0] rx_div;
   logic [2:0]  rx_bit;
   logic        rx_fall;
   logic        rx_tick;

   // Edge taken from s2->s1 to save a cycle; bit samples come from s2
   assign rx_fall = rx_s2 & ~rx_s1;
   assign rx_tick = (rx_cnt == 16'd0);
   assign rx_push = (rx_state == RX_STOP) && rx_tick && rx_s2;
   assign rx_ferr = (rx_state == RX_STOP) && rx_tick && !rx_s2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_div   <= DIV_RESET;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_s1 <= uart_rx;
         rx_s2 <= rx_s1;
         case (rx_state)
            RX_IDLE: begin
               if (rx_fall) begin
                  rx_div   <= div_q;
                  rx_cnt   <= {1'b0, div_q[15:1]};
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_tick) begin
                  if (rx_s2) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_cnt   <= rx_div - 16'd1;
                     rx_bit   <= '0;
                     rx_state <= RX_DATA;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_tick) begin
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_cnt   <= rx_div - 16'd1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_tick) rx_state <= rx_s2 ? RX_IDLE : RX_BREAK;
               else         rx_cnt   <= rx_cnt - 16'd1;
            end
            RX_BREAK: begin
               if (rx_s2) rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: doc/wb_uart.md
Name: wb_uart

Overview:
- Wishbone classic slave UART peripheral; decodes as one more I/O slave on the J1 bus alongside the existing wb_io ports.
- Drives the board UART_TX pin and receives on UART_RX.
- Format is 8N1, with a programmable baud divisor and small TX/RX FIFOs, so the J1 CPU polls status rather than bit-timing.
- All 16-bit data path, word addressed.

Parameters:
- FIFO_DEPTH, 8, entries per TX and RX FIFO; power of 2, minimum 2.
- DIV_RESET, 868, reset value of baud divisor in clk cycles per bit (100 MHz / 115200).

Ports:
- clk  input  1  system clock, single domain.
- reset_n  input  1  asynchronous active-low reset.
- wb_cyc  input  1  bus cycle.
- wb_stb  input  1  strobe.
- wb_we  input  1  write enable.
- wb_adr  input  2  word register select.
- wb_dat_i  input  16  write data.
- wb_dat_o  output  16  read data.
- wb_ack  output  1  acknowledge.
- uart_rx  input  1  serial input, asynchronous to clk.
- uart_tx  output  1  serial output.

Behaviour:
- Reset (async assert, sync release by upstream):
  - wb_ack=0, wb_dat_o=0, uart_tx=1.
  - Both FIFOs empty, divisor=DIV_RESET, sticky flags clear, both FSMs IDLE.
- Bus handshake:
  - wb_cyc&wb_stb&!wb_ack → wb_ack=1 the next cycle, exactly one cycle; no wait states.
  - The write side effect or read pop happens on the same edge that raises wb_ack.
  - wb_dat_o is valid while wb_ack=1, otherwise 0.
  - Back-to-back strobes therefore ack every other cycle.
- Register map:
  - adr 0 DATA.
    - Write pushes wb_dat_i[7:0] into TX FIFO. If TX FIFO is full the write is acked and dropped.
    - Read returns {8'h00, RX head} and pops. If RX is empty it returns 0 and does not pop.
  - adr 1 STATUS.
    - Read bits: [0] rx_avail, [1] tx_full, [2] tx_idle (FIFO empty and FSM IDLE), [3] ferr, [4] ovr; the rest read 0.
    - Write: bits 3/4 are write-1-to-clear; other bits are ignored.
  - adr 2 BAUD.
    - R/W 16-bit divisor; writes of 0 or 1 are stored as 2.
    - A new value applies from the next frame start; a frame in progress keeps its divisor.
  - adr 3: reads 0, writes ignored.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE with FIFO non-empty: pop, load shifter, go START on the next cycle.
  - Each state/bit holds uart_tx for exactly divisor cycles.
  - START drives 0; DATA sends 8 bits LSB first; STOP drives 1.
  - From STOP, if the FIFO is non-empty, go directly to START (no extra idle bit).
  - Frame length is 10×divisor cycles.
- RX path:
  - Two-flop synchroniser, then FSM IDLE → START → DATA → STOP.
  - IDLE: a falling edge loads counter = divisor/2.
  - START: at mid-bit, sample; if 1 (glitch) return to IDLE with no flags set.
  - DATA: sample 8 bits at divisor intervals, LSB first.
  - STOP: sample at mid-bit.
    - Stop=1: push byte.
    - Stop=0: discard byte, set ferr, wait for the line to return to 1 before IDLE.
  - RX FIFO full at push: drop the new byte, set ovr; FIFO contents are unchanged.
- Simultaneous events:
  - A FIFO push and pop in the same cycle are both honoured; count is unchanged, including at full.
  - A flag set and a W1C in the same cycle: the set wins.
- Reset mid-frame: immediate abort, uart_tx=1, FIFOs cleared.

Decomposition:
- Package uart_pkg holds:
  - Register address localparams (ADR_DATA=0, ADR_STATUS=1, ADR_BAUD=2).
  - STATUS bit index constants.
  - The tx_state_t/rx_state_t enums (IDLE, START, DATA, STOP).
- Sub-module uart_fifo: synchronous FIFO (WIDTH, DEPTH) with push, pop, dout, full, empty. Instantiated twice; pointer wrap uses the extra MSB.

Test Plan:
- Reset, read adr 1 → 16'h0004; read adr 2 → 868; uart_tx=1.
- Write BAUD=4, write DATA 16'h00A5 → uart_tx shows start bit 0, then 1,0,1,0,0,1,0,1, then stop 1; 4 cycles each, 40 cycles total; tx_idle=1 afterwards.
- BAUD=4, drive 0x3C serially on uart_rx → rx_avail=1; read DATA → 16'h003C; next read → 0 with rx_avail=0.
- Send 9 bytes with the FIFO unread → first 8 read back in order, ovr=1; write STATUS 16'h0010 → ovr=0.
- Drive a frame with stop=0 → no byte pushed, ferr=1; a 1-cycle low glitch on uart_rx → no byte, no flags.
- Write 10 bytes back-to-back → 8 accepted plus 1 popped by the FSM, tx_full observed, excess dropped; assert reset_n low mid-frame → uart_tx=1 immediately, status 16'h0004.
